// File: rtl/debounce_pkg.sv
// Shared types for the debounce/edge-detect block.
package debounce_pkg;

    typedef enum logic [1:0] {
        StStableLow  = 2'b00,
        StCheckHigh  = 2'b01,
        StStableHigh = 2'b10,
        StCheckLow   = 2'b11
    } deb_state_e;

endpackage

// File: rtl/debounce_edge_if.sv
// Signal bundle between a synchronised input source and the debouncer.
interface debounce_edge_if;

    logic sync_in;
    logic stable_out;
    logic rise_pulse;
    logic fall_pulse;

    modport master (
        output sync_in,
        input  stable_out,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  sync_in,
        output stable_out,
        output rise_pulse,
        output fall_pulse
    );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and enable; holds at rollover_val rather than wrapping.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != rollover_val)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/debounce_edge.sv
// Debounces an already-synchronised level and emits registered rise/fall pulses.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_BITS      = 8
) (
    input logic            clk,
    input logic            n_rst,
    debounce_edge_if.slave bus
);

    localparam logic [CNT_BITS-1:0] Limit = CNT_BITS'(STABLE_CYCLES - 1);

    deb_state_e state_q;
    logic       stable_q;
    logic       rise_q;
    logic       fall_q;
    logic       cnt_clear;
    logic       cnt_en;
    logic       at_limit;

    // The counter tracks how many consecutive samples disagree with the accepted level.
    always_comb begin
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            StStableLow: begin
                if (bus.sync_in) begin
                    cnt_clear = 1'b0;
                    cnt_en    = 1'b1;
                end
            end
            StCheckHigh: begin
                if (bus.sync_in && !at_limit) begin
                    cnt_clear = 1'b0;
                    cnt_en    = 1'b1;
                end
            end
            StStableHigh: begin
                if (!bus.sync_in) begin
                    cnt_clear = 1'b0;
                    cnt_en    = 1'b1;
                end
            end
            StCheckLow: begin
                if (!bus.sync_in && !at_limit) begin
                    cnt_clear = 1'b0;
                    cnt_en    = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
                cnt_en    = 1'b0;
            end
        endcase
    end

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (Limit),
        .rollover_flag (at_limit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StStableLow;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                StStableLow: begin
                    if (bus.sync_in) begin
                        state_q <= StCheckHigh;
                    end
                end
                StCheckHigh: begin
                    if (!bus.sync_in) begin
                        state_q <= StStableLow;
                    end else if (at_limit) begin
                        state_q  <= StStableHigh;
                        stable_q <= 1'b1;
                        rise_q   <= 1'b1;
                    end
                end
                StStableHigh: begin
                    if (!bus.sync_in) begin
                        state_q <= StCheckLow;
                    end
                end
                StCheckLow: begin
                    if (bus.sync_in) begin
                        state_q <= StStableHigh;
                    end else if (at_limit) begin
                        state_q  <= StStableLow;
                        stable_q <= 1'b0;
                        fall_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StStableLow;
                    stable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stable_out = stable_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: number of consecutive identical samples required to accept a new level; legal range 2..255.
REQ-002 SHALL have parameter CNT_BITS, default 8: counter width; SHALL hold STABLE_CYCLES.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sync_in, input, 1 bit: level already passed through the two-flop synchronizer; this block adds no synchronizer flops.
REQ-006 SHALL have port stable_out, output, 1 bit: debounced level, registered.
REQ-007 SHALL have port rise_pulse, output, 1 bit: one-cycle pulse when stable_out goes 0->1, registered.
REQ-008 SHALL have port fall_pulse, output, 1 bit: one-cycle pulse when stable_out goes 1->0, registered.

Function
REQ-009 SHALL sample sync_in on every rising clk edge while n_rst is high.
REQ-010 SHALL implement a four-state FSM: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
REQ-011 STABLE_LOW with sample 1 SHALL go to CHECK_HIGH, count=1; with sample 0 SHALL stay, count=0.
REQ-012 CHECK_HIGH with sample 1 and count<STABLE_CYCLES-1 SHALL stay, count+1.
REQ-013 CHECK_HIGH with sample 1 and count==STABLE_CYCLES-1 SHALL go to STABLE_HIGH, count=0, stable_out=1, rise_pulse=1 for exactly that next cycle.
REQ-014 CHECK_HIGH with sample 0 SHALL return to STABLE_LOW, count=0, no pulse, stable_out unchanged (0).
REQ-015 STABLE_HIGH, CHECK_LOW SHALL mirror REQ-011..014 with levels inverted and fall_pulse instead of rise_pulse.
REQ-016 Latency: first new-level sample at edge k SHALL make stable_out change immediately after edge k+STABLE_CYCLES-1, with no earlier change.
REQ-017 rise_pulse and fall_pulse SHALL never be high simultaneously and SHALL each be high at most one cycle per transition.
REQ-018 stable_out SHALL equal 1 exactly in STABLE_HIGH and CHECK_LOW.
REQ-019 Counter SHALL never exceed STABLE_CYCLES-1 and SHALL NOT wrap.
REQ-020 A glitch shorter than STABLE_CYCLES samples SHALL produce no output change and no pulse.

Reset
REQ-021 n_rst low SHALL immediately, without a clock, force state STABLE_LOW, count 0, stable_out 0, rise_pulse 0, fall_pulse 0.
REQ-022 Reset asserted mid-CHECK_HIGH or mid-CHECK_LOW SHALL discard the partial count; after release, qualification SHALL restart from REQ-011.
REQ-023 The first sample SHALL be taken on the first rising edge after n_rst is released.

Structure
REQ-024 A package debounce_pkg SHALL hold the FSM state enum type.
REQ-025 The counter SHALL be a sub-module flex_counter, with synchronous clear, count-enable, and rollover value STABLE_CYCLES-1.
REQ-026 All outputs SHALL come directly from flops; no combinational path from sync_in to any output.

Verification (STABLE_CYCLES=4, 10 ns clock, stimulus applied on the negative edge)
REQ-027 Reset applied with sync_in=1 mid-cycle -> all outputs 0 immediately; still 0 after 2 clocks in reset.
REQ-028 sync_in 0->1, held 6 cycles -> stable_out 1 after the 4th sampling edge; rise_pulse high exactly 1 cycle, coincident with the stable_out change.
REQ-029 From STABLE_HIGH, sync_in 1->0 held 4 cycles -> stable_out 0 after the 4th edge; fall_pulse 1 cycle; rise_pulse stays 0.
REQ-030 sync_in high for 3 cycles then low -> stable_out, rise_pulse, fall_pulse stay 0 throughout; FSM back in STABLE_LOW.
REQ-031 sync_in high 2 cycles, n_rst pulsed low, released, sync_in still high -> stable_out rises only 4 edges after release.
REQ-032 100-cycle pseudo-random sync_in stream -> a scoreboard model matches stable_out and the pulses every cycle; the pulses are never simultaneous.
